keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scan controller for a 4x4 matrix keypad. It drives a one-hot column ring (1000 → 0100 → 0010 → 0001), samples the row lines, and debounces a single pressed key over whole scan frames. It rejects multi-key (ghosting) frames and presents a 4-bit key code to downstream logic through a valid/ack handshake. It sits between the keypad pins and the display/command logic, and replaces a free-running column sweep with a self-timed scanner.

## Interface

Parameters:
- SCAN_DIV, 4, clock cycles per column dwell; legal range 2..256.
- DEBOUNCE, 3, consecutive identical frames required to accept a press, and consecutive empty frames required to accept a release; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- row  input  4  row sense lines, active-high; row[i] high means a key at (active column, row i) is pressed.
- col  output  4  one-hot column drive.
- key_code  output  4  accepted key, {col_idx[1:0], row_idx[1:0]}; col_idx 0..3 for col 1000/0100/0010/0001.
- key_valid  output  1  key_code holds an unconsumed key.
- key_ack  input  1  consumer accepts key_code; meaningful only while key_valid=1.
- overrun  output  1  one-cycle pulse when an accepted key is dropped because key_valid was still set.

## Operation

- **Reset values:** col=1000, key_code=0, key_valid=0, overrun=0; dwell counter=0; frame accumulator cleared; FSM=IDLE; debounce count=0.
- **Column ring:**
  - The dwell counter counts 0..SCAN_DIV-1.
  - On the edge where the counter equals SCAN_DIV-1 (the sample edge), row is sampled for the current column and col rotates right, wrapping 0001 → 1000.
- **Frame accumulator:**
  - Per frame it records the hit count (saturating at 2) and the code of the first hit.
  - Within a column, the lowest set row bit gives row_idx. Two or more set bits in one column count as 2.
- **Frame end:** the sample edge of column 0001. The frame result uses this column's combinational sample.
  - Result classes: NONE (0 hits), SINGLE(code) (1 hit), MULTI (2 or more hits).
  - The accumulator clears at the same edge.
- **FSM transitions (evaluated only at frame end):**
  - IDLE: SINGLE(c) → cand=c, cnt=1, go to DEBOUNCE; if DEBOUNCE=1, emit c and go to PRESSED instead. NONE or MULTI → stay in IDLE.
  - DEBOUNCE: SINGLE(cand) → cnt+1; when cnt+1 reaches DEBOUNCE, emit cand and go to PRESSED. SINGLE(other), NONE or MULTI → IDLE, cnt=0.
  - PRESSED: NONE → RELEASE, cnt=1; if DEBOUNCE=1, go to IDLE instead. Any hit → stay in PRESSED. No re-emit, no auto-repeat.
  - RELEASE: NONE → cnt+1; when cnt+1 reaches DEBOUNCE, go to IDLE. Any hit → PRESSED.
- **Emit:**
  - If key_valid=0, or key_valid=1 with key_ack=1 on the same edge: key_code=cand, key_valid=1.
  - Otherwise: key_code and key_valid are unchanged, and overrun=1 for exactly one cycle.
- **Handshake:**
  - key_valid=1 with key_ack=1 at an edge with no emit → key_valid=0 next cycle.
  - key_ack while key_valid=0 is ignored.
  - key_code is stable while key_valid=1.
- **Reset mid-operation:** all state returns to reset values at the next edge. A partially debounced key is discarded, and a pending key is lost without an overrun pulse.

## Timing

- Frame length is 4*SCAN_DIV cycles.
- The first frame after rst deassertion starts with col=1000 and dwell counter=0.
- **Press latency:** a key held stable from a frame start sets key_valid in the cycle after the DEBOUNCE-th frame-end edge, i.e. DEBOUNCE*4*SCAN_DIV cycles after that frame start.
- **Release:** takes DEBOUNCE empty frames. The next press then needs a further DEBOUNCE frames.
- **Ack:** key_valid falls the cycle after the ack edge, giving one-cycle turnaround. Back-to-back keys are possible at frame-end granularity only.
- overrun is registered, high for one cycle following the frame-end edge.

## Test plan

All scenarios use SCAN_DIV=4 and DEBOUNCE=3, so one frame is 16 cycles.

- **Reset and ring:** assert rst for 2 cycles, no keys → col=1000, key_valid=0, overrun=0, key_code=0. col then follows 1000, 0100, 0010, 0001, 1000, changing every 4 cycles, and key_valid never rises.
- **Single press:** model drives row[2]=1 whenever col=0010, from frame start → key_valid rises 48 cycles later with key_code=4'hA. Ack at an arbitrary later cycle → key_valid=0 next cycle. Key held for 10 more frames → no further key_valid.
- **Bounce:** key 4'hA present 2 frames, absent 1 frame, present 3 frames → exactly one key_valid, after the last of those 3 frames.
- **Ghosting:** keys (col 0100, row 0) and (col 0001, row 3) held together for 6 frames → key_valid stays 0. Release the second key → 4'h4 accepted 3 frames later.
- **Overrun:** accept 4'hA with no ack, release for 3 frames, then press (col 0100, row 1) for 3 frames → one-cycle overrun pulse; key_code stays 4'hA and key_valid stays 1.
- **Reset mid-debounce:** pulse rst after 2 frames of 4'hA → col=1000, and key_valid appears only 3 full frames after rst deasserts.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-hot column ring, per-frame hit accumulation, frame-level
// debounce FSM with ghost rejection, and a valid/ack key output with overrun flag.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       overrun
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [4:0] DB = 5'(DEBOUNCE);

   typedef enum logic [1:0] {S_IDLE, S_DEBNC, S_PRESSED, S_RELEASE} state_t;

   logic [DW-1:0] div_q, div_d;
   logic [3:0]    col_q, col_d;
   logic [1:0]    acc_hits_q, acc_hits_d;
   logic [3:0]    acc_code_q, acc_code_d;
   state_t        state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    dcnt_q, dcnt_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          overrun_q, overrun_d;

   logic       sample, frame_end;
   logic [1:0] col_idx, row_idx, col_hits, frame_hits;
   logic [2:0] hit_sum;
   logic [3:0] row_lo, frame_code, emit_code;
   logic [4:0] dcnt_inc;
   logic       emit, is_none, is_single;

   assign sample    = (div_q == DIV_LAST);
   assign frame_end = sample && (col_q == 4'b0001);

   always_comb begin
      case (col_q)
         4'b1000: col_idx = 2'd0;
         4'b0100: col_idx = 2'd1;
         4'b0010: col_idx = 2'd2;
         default: col_idx = 2'd3;
      endcase
   end

   always_comb begin
      if (row[0])      row_idx = 2'd0;
      else if (row[1]) row_idx = 2'd1;
      else if (row[2]) row_idx = 2'd2;
      else             row_idx = 2'd3;
   end

   // Clearing the lowest set bit leaves zero only when exactly one row is active.
   assign row_lo     = row & (row - 4'd1);
   assign col_hits   = (row == 4'd0) ? 2'd0 : ((row_lo == 4'd0) ? 2'd1 : 2'd2);
   assign hit_sum    = {1'b0, acc_hits_q} + {1'b0, col_hits};
   assign frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
   assign frame_code = (acc_hits_q == 2'd0) ? {col_idx, row_idx} : acc_code_q;
   assign is_none    = (frame_hits == 2'd0);
   assign is_single  = (frame_hits == 2'd1);
   assign dcnt_inc   = {1'b0, dcnt_q} + 5'd1;

   always_comb begin
      div_d      = sample ? '0 : div_q + DW'(1);
      col_d      = sample ? {col_q[0], col_q[3:1]} : col_q;
      acc_hits_d = acc_hits_q;
      acc_code_d = acc_code_q;
      if (frame_end) begin
         acc_hits_d = 2'd0;
         acc_code_d = 4'd0;
      end else if (sample) begin
         acc_hits_d = frame_hits;
         acc_code_d = frame_code;
      end
   end

   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      dcnt_d    = dcnt_q;
      emit      = 1'b0;
      emit_code = cand_q;
      if (frame_end) begin
         case (state_q)
            S_IDLE: begin
               if (is_single) begin
                  cand_d    = frame_code;
                  emit_code = frame_code;
                  if (DB == 5'd1) begin
                     emit    = 1'b1;
                     state_d = S_PRESSED;
                     dcnt_d  = 4'd0;
                  end else begin
                     state_d = S_DEBNC;
                     dcnt_d  = 4'd1;
                  end
               end
            end
            S_DEBNC: begin
               if (is_single && frame_code == cand_q) begin
                  if (dcnt_inc == DB) begin
                     emit    = 1'b1;
                     state_d = S_PRESSED;
                     dcnt_d  = 4'd0;
                  end else begin
                     dcnt_d = dcnt_inc[3:0];
                  end
               end else begin
                  state_d = S_IDLE;
                  dcnt_d  = 4'd0;
               end
            end
            S_PRESSED: begin
               if (is_none) begin
                  if (DB == 5'd1) begin
                     state_d = S_IDLE;
                     dcnt_d  = 4'd0;
                  end else begin
                     state_d = S_RELEASE;
                     dcnt_d  = 4'd1;
                  end
               end
            end
            default: begin
               if (!is_none) begin
                  state_d = S_PRESSED;
                  dcnt_d  = 4'd0;
               end else if (dcnt_inc == DB) begin
                  state_d = S_IDLE;
                  dcnt_d  = 4'd0;
               end else begin
                  dcnt_d = dcnt_inc[3:0];
               end
            end
         endcase
      end
   end

   // An ack on the emit edge frees the slot, so the new key may replace the old one.
   always_comb begin
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      overrun_d   = 1'b0;
      if (emit) begin
         if (!key_valid_q || key_ack) begin
            key_code_d  = emit_code;
            key_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (key_valid_q && key_ack) begin
         key_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q       <= '0;
         col_q       <= 4'b1000;
         acc_hits_q  <= 2'd0;
         acc_code_q  <= 4'd0;
         state_q     <= S_IDLE;
         cand_q      <= 4'd0;
         dcnt_q      <= 4'd0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         div_q       <= div_d;
         col_q       <= col_d;
         acc_hits_q  <= acc_hits_d;
         acc_code_q  <= acc_code_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         dcnt_q      <= dcnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign col       = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE=3, 16-cycle frames);
// a behavioural keypad drives row from col and the set of pressed keys.
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ack;
   logic       overrun;

   logic [15:0] pressed;
   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic seen;

   keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ack   (key_ack),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Key code {c,r} closes row r while column c (1000 = 0) is driven.
   always_comb begin
      row = 4'd0;
      for (int c = 0; c < 4; c++) begin
         if (col[3-c]) begin
            for (int r = 0; r < 4; r++) begin
               if (pressed[c*4+r]) row[r] = 1'b1;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic tick_watch(input int n);
      repeat (n) begin
         tick(1);
         if (key_valid) seen = 1'b1;
      end
   endtask

   task automatic align();
      while (cyc % 16 != 0) tick(1);
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst     = 1'b1;
      key_ack = 1'b0;
      pressed = 16'd0;

      // Reset and ring
      tick(2);
      check("rst_col", col, 4'b1000);
      check("rst_valid", {3'd0, key_valid}, 4'd0);
      check("rst_overrun", {3'd0, overrun}, 4'd0);
      check("rst_code", key_code, 4'd0);
      rst = 1'b0;
      cyc = 0;
      tick(3);
      check("ring_hold", col, 4'b1000);
      tick(1);
      check("ring_1", col, 4'b0100);
      tick(4);
      check("ring_2", col, 4'b0010);
      tick(4);
      check("ring_3", col, 4'b0001);
      seen = 1'b0;
      tick_watch(4);
      check("ring_wrap", col, 4'b1000);
      check("ring_no_valid", {3'd0, seen}, 4'd0);

      // Single press of 4'hA from a frame start
      pressed[4'hA] = 1'b1;
      tick(47);
      check("press_early", {3'd0, key_valid}, 4'd0);
      tick(1);
      check("press_valid", {3'd0, key_valid}, 4'd1);
      check("press_code", key_code, 4'hA);
      tick(5);
      check("press_stable", key_code, 4'hA);
      key_ack = 1'b1;
      tick(1);
      key_ack = 1'b0;
      check("ack_clear", {3'd0, key_valid}, 4'd0);
      seen = 1'b0;
      tick_watch(160);
      check("hold_no_repeat", {3'd0, seen}, 4'd0);

      // Bounce: 2 on, 1 off, 3 on
      pressed = 16'd0;
      align();
      tick(48);
      pressed[4'hA] = 1'b1;
      seen = 1'b0;
      tick_watch(32);
      pressed[4'hA] = 1'b0;
      tick_watch(16);
      pressed[4'hA] = 1'b1;
      tick_watch(47);
      check("bounce_early", {3'd0, seen}, 4'd0);
      tick(1);
      check("bounce_valid", {3'd0, key_valid}, 4'd1);
      check("bounce_code", key_code, 4'hA);
      key_ack = 1'b1;
      tick(1);
      key_ack = 1'b0;
      seen = 1'b0;
      tick_watch(32);
      check("bounce_once", {3'd0, seen}, 4'd0);

      // Ghosting: 4'h4 and 4'hF together, then release 4'hF
      pressed = 16'd0;
      align();
      tick(48);
      pressed[4'h4] = 1'b1;
      pressed[4'hF] = 1'b1;
      seen = 1'b0;
      tick_watch(96);
      check("ghost_reject", {3'd0, seen}, 4'd0);
      pressed[4'hF] = 1'b0;
      tick_watch(47);
      check("ghost_early", {3'd0, seen}, 4'd0);
      tick(1);
      check("ghost_valid", {3'd0, key_valid}, 4'd1);
      check("ghost_code", key_code, 4'h4);
      key_ack = 1'b1;
      tick(1);
      key_ack = 1'b0;
      check("ghost_ack", {3'd0, key_valid}, 4'd0);

      // Overrun: 4'hA pending, then 4'h5 accepted
      pressed = 16'd0;
      align();
      tick(48);
      pressed[4'hA] = 1'b1;
      tick(48);
      check("ovr_first_valid", {3'd0, key_valid}, 4'd1);
      check("ovr_first_code", key_code, 4'hA);
      pressed = 16'd0;
      tick(48);
      pressed[4'h5] = 1'b1;
      tick(47);
      check("ovr_quiet", {3'd0, overrun}, 4'd0);
      tick(1);
      check("ovr_pulse", {3'd0, overrun}, 4'd1);
      check("ovr_code_kept", key_code, 4'hA);
      check("ovr_valid_kept", {3'd0, key_valid}, 4'd1);
      tick(1);
      check("ovr_one_cycle", {3'd0, overrun}, 4'd0);

      // Reset mid-debounce with a key still pending
      pressed = 16'd0;
      align();
      tick(48);
      pressed[4'hA] = 1'b1;
      tick(32);
      rst = 1'b1;
      tick(1);
      check("mid_rst_col", col, 4'b1000);
      check("mid_rst_valid", {3'd0, key_valid}, 4'd0);
      check("mid_rst_code", key_code, 4'd0);
      check("mid_rst_overrun", {3'd0, overrun}, 4'd0);
      rst = 1'b0;
      cyc = 0;
      seen = 1'b0;
      tick_watch(47);
      check("mid_rst_early", {3'd0, seen}, 4'd0);
      tick(1);
      check("mid_rst_valid_late", {3'd0, key_valid}, 4'd1);
      check("mid_rst_code_late", key_code, 4'hA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
